// File: rtl/instr_fetch.sv
// Instruction fetch front-end: owns the fetch PC, drives the IRAM word address,
// tracks the one-cycle registered read and buffers {instr, pc} for decode.
module instr_fetch #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 5,
  parameter int RESET_PC  = 0,
  parameter int DEPTH     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  output logic [ADDRWIDTH-1:0] iram_addr_o,
  input  logic [DATAWIDTH-1:0] iram_data_i,
  input  logic                 redirect_i,
  input  logic [ADDRWIDTH-1:0] redirect_pc_i,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  output logic [DATAWIDTH-1:0] instr_o,
  output logic [ADDRWIDTH-1:0] instr_pc_o
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [PTRW-1:0]      LAST_PTR   = PTRW'(DEPTH - 1);
  localparam logic [PTRW-1:0]      PTR_ONE    = PTRW'(1);
  localparam logic [CNTW-1:0]      CNT_ONE    = CNTW'(1);
  localparam logic [CNTW-1:0]      CNT_FULL   = CNTW'(DEPTH);
  localparam logic [CNTW:0]        DEPTH_C    = (CNTW+1)'(DEPTH);
  localparam logic [ADDRWIDTH-1:0] ADDR_ONE   = ADDRWIDTH'(1);
  localparam logic [ADDRWIDTH-1:0] RESET_ADDR = ADDRWIDTH'(RESET_PC);

  if (DEPTH < 2) begin : g_depth_check
    $error("instr_fetch: DEPTH must be >= 2");
  end

  logic [ADDRWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                 inflight_q, inflight_d;
  logic [ADDRWIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [PTRW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]      count_q, count_d;
  logic [DATAWIDTH-1:0] data_q [DEPTH];
  logic [DATAWIDTH-1:0] data_d [DEPTH];
  logic [ADDRWIDTH-1:0] pc_q   [DEPTH];
  logic [ADDRWIDTH-1:0] pc_d   [DEPTH];
  logic                 pop;
  logic                 push;
  logic                 issue;
  logic [CNTW:0]        occupancy;

  assign iram_addr_o   = redirect_i ? redirect_pc_i : fetch_pc_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = data_q[rd_ptr_q];
  assign instr_pc_o    = pc_q[rd_ptr_q];

  assign pop  = instr_valid_o & instr_ready_i;
  assign push = inflight_q & ~redirect_i;

  // Slots already committed after this edge; a new read is only started if its word has a home.
  assign occupancy = {1'b0, count_q} + {{CNTW{1'b0}}, inflight_q} - {{CNTW{1'b0}}, pop};
  assign issue     = redirect_i | (occupancy < DEPTH_C);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    data_d        = data_q;
    pc_d          = pc_q;

    if (issue) begin
      inflight_pc_d = iram_addr_o;
      fetch_pc_d    = iram_addr_o + ADDR_ONE;
    end

    if (redirect_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = iram_data_i;
        pc_d[wr_ptr_q]   = inflight_pc_q;
        wr_ptr_d         = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q    <= RESET_ADDR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      data_q        <= data_d;
      pc_q          <= pc_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && !pop && (count_q == CNT_FULL)))
    else $error("instr_fetch: push into full FIFO");

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with fixed expectations, then a random
// ready/redirect run checked against a queue-based reference model.
module tb_instr_fetch;
  localparam int DW       = 32;
  localparam int AW       = 5;
  localparam int RESET_PC = 0;
  localparam int DEPTH    = 2;
  localparam int N_STREAM = 10;

  typedef struct {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] iram_addr_o;
  logic [DW-1:0] iram_data;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          instr_valid_o;
  logic          ready;
  logic [DW-1:0] instr_o;
  logic [AW-1:0] instr_pc_o;

  logic [DW-1:0] mem [32];

  ent_t          m_q[$];
  logic          m_infl    = 1'b0;
  logic [AW-1:0] m_infl_pc = '0;
  logic [AW-1:0] m_pc      = AW'(RESET_PC);

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch #(
    .DATAWIDTH(DW), .ADDRWIDTH(AW), .RESET_PC(RESET_PC), .DEPTH(DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .iram_addr_o  (iram_addr_o),
    .iram_data_i  (iram_data),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(ready),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o)
  );

  always #5 clk = ~clk;

  // IRAM: registered read, no enable.
  always @(posedge clk) iram_data <= mem[iram_addr_o];

  // Reference: a bounded queue of {instr, pc} plus at most one outstanding read.
  task automatic model_edge();
    ent_t e;
    bit   pop_m;
    if (!rst_n) begin
      m_q.delete();
      m_infl = 1'b0;
      m_pc   = AW'(RESET_PC);
      return;
    end
    pop_m = (m_q.size() != 0) && ready;
    if (redirect) begin
      m_q.delete();
      m_infl    = 1'b1;
      m_infl_pc = redirect_pc;
      m_pc      = redirect_pc + AW'(1);
    end else begin
      if (pop_m) void'(m_q.pop_front());
      if (m_infl) begin
        e.instr = mem[m_infl_pc];
        e.pc    = m_infl_pc;
        m_q.push_back(e);
      end
      m_infl = (m_q.size() < DEPTH);
      if (m_infl) begin
        m_infl_pc = m_pc;
        m_pc      = m_pc + AW'(1);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step();
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", instr_valid_o); end
    n_cmp++; if (instr_o !== '0) begin n_err++; $display("FAIL reset_instr: got %h expected 0", instr_o); end
    n_cmp++; if (instr_pc_o !== '0) begin n_err++; $display("FAIL reset_pc: got %0d expected 0", instr_pc_o); end
    n_cmp++; if (iram_addr_o !== AW'(RESET_PC)) begin n_err++; $display("FAIL reset_addr: got %0d expected %0d", iram_addr_o, RESET_PC); end
  endtask

  task automatic test_stream();
    rst_n = 1'b1; ready = 1'b1;
    step();
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL stream_edge1_valid: got %b expected 0", instr_valid_o); end
    n_cmp++; if (iram_addr_o !== AW'(RESET_PC + 1)) begin n_err++; $display("FAIL stream_edge1_addr: got %0d expected %0d", iram_addr_o, RESET_PC + 1); end
    for (int k = 0; k < N_STREAM; k++) begin
      step();
      n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, instr_valid_o); end
      n_cmp++; if (instr_pc_o !== AW'(k)) begin n_err++; $display("FAIL stream_pc[%0d]: got %0d expected %0d", k, instr_pc_o, k); end
      n_cmp++; if (instr_o !== DW'(32'h1000 + k)) begin n_err++; $display("FAIL stream_instr[%0d]: got %h expected %h", k, instr_o, 32'h1000 + k); end
    end
  endtask

  task automatic test_stall();
    int h;
    h = N_STREAM - 1;
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, instr_valid_o); end
      n_cmp++; if (instr_pc_o !== AW'(h)) begin n_err++; $display("FAIL stall_pc[%0d]: got %0d expected %0d", i, instr_pc_o, h); end
      n_cmp++; if (instr_o !== DW'(32'h1000 + h)) begin n_err++; $display("FAIL stall_instr[%0d]: got %h expected %h", i, instr_o, 32'h1000 + h); end
      n_cmp++; if (iram_addr_o !== AW'(h + 2)) begin n_err++; $display("FAIL stall_addr[%0d]: got %0d expected %0d", i, iram_addr_o, h + 2); end
    end
    ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL resume_valid[%0d]: got %b expected 1", k, instr_valid_o); end
      n_cmp++; if (instr_pc_o !== AW'(h + k)) begin n_err++; $display("FAIL resume_pc[%0d]: got %0d expected %0d", k, instr_pc_o, h + k); end
    end
  endtask

  task automatic test_redirect_full();
    int h;
    h = N_STREAM - 1 + 6;
    ready = 1'b0;
    step();
    n_cmp++; if (instr_pc_o !== AW'(h)) begin n_err++; $display("FAIL full_head_pc: got %0d expected %0d", instr_pc_o, h); end
    redirect = 1'b1; redirect_pc = AW'(20);
    #1;
    n_cmp++; if (iram_addr_o !== AW'(20)) begin n_err++; $display("FAIL redir_addr: got %0d expected 20", iram_addr_o); end
    step();
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL redir_flush_valid: got %b expected 0", instr_valid_o); end
    redirect = 1'b0; ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL redir_valid[%0d]: got %b expected 1", k, instr_valid_o); end
      n_cmp++; if (instr_pc_o !== AW'(20 + k)) begin n_err++; $display("FAIL redir_pc[%0d]: got %0d expected %0d", k, instr_pc_o, 20 + k); end
      n_cmp++; if (instr_o !== DW'(32'h1000 + 20 + k)) begin n_err++; $display("FAIL redir_instr[%0d]: got %h expected %h", k, instr_o, 32'h1000 + 20 + k); end
    end
  endtask

  task automatic test_wrap();
    int exp_pc[4] = '{30, 31, 0, 1};
    ready = 1'b1; redirect = 1'b1; redirect_pc = AW'(30);
    step();
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL wrap_flush_valid: got %b expected 0", instr_valid_o); end
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (instr_pc_o !== AW'(exp_pc[i])) begin n_err++; $display("FAIL wrap_pc[%0d]: got %0d expected %0d", i, instr_pc_o, exp_pc[i]); end
      n_cmp++; if (instr_o !== DW'(32'h1000 + exp_pc[i])) begin n_err++; $display("FAIL wrap_instr[%0d]: got %h expected %h", i, instr_o, 32'h1000 + exp_pc[i]); end
    end
  endtask

  task automatic test_back_to_back();
    ready = 1'b1; redirect = 1'b1; redirect_pc = AW'(5);
    step();
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_first_valid: got %b expected 0", instr_valid_o); end
    redirect_pc = AW'(9);
    step();
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_second_valid: got %b expected 0", instr_valid_o); end
    redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b expected 1", k, instr_valid_o); end
      n_cmp++; if (instr_pc_o !== AW'(9 + k)) begin n_err++; $display("FAIL b2b_pc[%0d]: got %0d expected %0d", k, instr_pc_o, 9 + k); end
    end
  endtask

  task automatic test_reset_midstream();
    n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid: got %b expected 1", instr_valid_o); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b expected 0", instr_valid_o); end
    n_cmp++; if (instr_pc_o !== '0) begin n_err++; $display("FAIL midrst_pc: got %0d expected 0", instr_pc_o); end
    n_cmp++; if (instr_o !== '0) begin n_err++; $display("FAIL midrst_instr: got %h expected 0", instr_o); end
    n_cmp++; if (iram_addr_o !== AW'(RESET_PC)) begin n_err++; $display("FAIL midrst_addr: got %0d expected %0d", iram_addr_o, RESET_PC); end
    step();
    step();
    rst_n = 1'b1; ready = 1'b1;
    step();
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL midrst_edge1_valid: got %b expected 0", instr_valid_o); end
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++; if (instr_pc_o !== AW'(k)) begin n_err++; $display("FAIL midrst_pc[%0d]: got %0d expected %0d", k, instr_pc_o, k); end
      n_cmp++; if (instr_o !== DW'(32'h1000 + k)) begin n_err++; $display("FAIL midrst_instr[%0d]: got %h expected %h", k, instr_o, 32'h1000 + k); end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] exp_addr;
    for (int c = 0; c < 600; c++) begin
      ready       = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = AW'($urandom);
      #1;
      exp_addr = redirect ? redirect_pc : m_pc;
      n_cmp++; if (iram_addr_o !== exp_addr) begin n_err++; $display("FAIL rand_addr[%0d]: got %0d expected %0d", c, iram_addr_o, exp_addr); end
      step();
      n_cmp++; if (instr_valid_o !== (m_q.size() != 0)) begin n_err++; $display("FAIL rand_valid[%0d]: got %b expected %b", c, instr_valid_o, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        n_cmp++; if (instr_pc_o !== m_q[0].pc) begin n_err++; $display("FAIL rand_pc[%0d]: got %0d expected %0d", c, instr_pc_o, m_q[0].pc); end
        n_cmp++; if (instr_o !== m_q[0].instr) begin n_err++; $display("FAIL rand_instr[%0d]: got %h expected %h", c, instr_o, m_q[0].instr); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no end of test expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000 + i;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_wrap();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
